fb_rect_writer: RTL

Frame-buffer write-side engine, the producer for the 320x240 RGB565 buffer that the VGA scan-out reads.
- Accepts rectangle-fill commands over a valid/ready handshake.
- Emits one pixel write per clock on the buffer's write port, using linear address y*FB_W + x.
- Sits between game/draw logic and the dual-port frame buffer, on the same clock domain as the buffer write port.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_addr_gen.sv | 72 +++++++
 rtl/fb_rect_writer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Frame-buffer geometry, RGB565 field positions and the rectangle command type.
// Shared by the write-side fill engine and the scan-out reader.
package fb_pkg;

  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int FB_AW = 17;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [8:0]  w;
    logic [7:0]  h;
    logic [15:0] color;
  } rect_cmd_t;

  // y*320 without a multiplier: y*256 + y*64
  function automatic logic [FB_AW-1:0] row_base_of(input logic [7:0] y);
    return {1'b0, y, 8'h00} + {3'b000, y, 6'h00};
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Column/row walker for a rectangle fill; holds the current write address and
// flags the last pixel. Load on accept, step once per write after the first.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int AW   = fb_pkg::FB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [8:0]    i_x,
  input  logic [7:0]    i_y,
  input  logic [8:0]    i_w,
  input  logic [7:0]    i_h,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [8:0]    r_col;
  logic [7:0]    r_row;
  logic [AW-1:0] r_row_base;
  logic [8:0]    r_x0;
  logic [8:0]    r_w;
  logic [7:0]    r_h;
  logic [AW-1:0] r_addr;

  logic          w_col_wrap;
  logic          w_row_last;
  logic [AW-1:0] w_row_base_ld;
  logic [AW-1:0] w_row_base_nxt;

  assign w_col_wrap     = (r_col == r_w - 9'd1);
  assign w_row_last     = (r_row == r_h - 8'd1);
  assign w_row_base_ld  = AW'(row_base_of(i_y));
  assign w_row_base_nxt = r_row_base + AW'(FB_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_x0       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_addr     <= '0;
    end else if (i_load) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= w_row_base_ld;
      r_x0       <= i_x;
      r_w        <= i_w;
      r_h        <= i_h;
      r_addr     <= w_row_base_ld + AW'(i_x);
    end else if (i_step) begin
      if (w_col_wrap) begin
        r_col      <= '0;
        r_row      <= r_row + 8'd1;
        r_row_base <= w_row_base_nxt;
        r_addr     <= w_row_base_nxt + AW'(r_x0);
      end else begin
        r_col      <= r_col + 9'd1;
        r_addr     <= r_addr + AW'(1);
      end
    end
  end

  assign o_addr = r_addr;
  assign o_last = w_col_wrap && w_row_last;

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine feeding the frame-buffer write port, one pixel per clock.
// Define FB_RECT_WRITER_CLIP_EN to clip out-of-bounds rectangles instead of rejecting them.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H,
  parameter int AW   = fb_pkg::FB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [8:0]    cmd_x,
  input  logic [7:0]    cmd_y,
  input  logic [8:0]    cmd_w,
  input  logic [7:0]    cmd_h,
  input  logic [15:0]   cmd_color,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [15:0]   fb_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FIN} state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_we;
  logic [15:0] r_data;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  rect_cmd_t   w_cmd;
  logic        w_accept;
  logic        w_step;
  logic        w_last;
  logic [8:0]  w_w_eff;
  logic [7:0]  w_h_eff;
  logic        w_reject;
  logic        w_zero;

  assign w_cmd = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};

`ifdef FB_RECT_WRITER_CLIP_EN
  logic       w_oob;
  logic [9:0] w_w_room;
  logic [9:0] w_h_room;

  assign w_oob    = ({1'b0, w_cmd.x} >= 10'(FB_W)) || ({2'b00, w_cmd.y} >= 10'(FB_H));
  assign w_w_room = 10'(FB_W) - {1'b0, w_cmd.x};
  assign w_h_room = 10'(FB_H) - {2'b00, w_cmd.y};
  assign w_w_eff  = w_oob ? 9'd0 : (({1'b0, w_cmd.w} > w_w_room) ? 9'(w_w_room) : w_cmd.w);
  assign w_h_eff  = w_oob ? 8'd0 : (({2'b00, w_cmd.h} > w_h_room) ? 8'(w_h_room) : w_cmd.h);
  assign w_reject = 1'b0;
`else
  logic [9:0] w_x_end;
  logic [9:0] w_y_end;

  // 10-bit sums so x0+w and y0+h cannot wrap past the limit
  assign w_x_end  = {1'b0, w_cmd.x} + {1'b0, w_cmd.w};
  assign w_y_end  = {2'b00, w_cmd.y} + {2'b00, w_cmd.h};
  assign w_w_eff  = w_cmd.w;
  assign w_h_eff  = w_cmd.h;
  assign w_reject = (w_x_end > 10'(FB_W)) || (w_y_end > 10'(FB_H));
`endif

  assign w_zero   = (w_w_eff == 9'd0) || (w_h_eff == 8'd0);
  assign w_accept = cmd_valid && r_ready;
  assign w_step   = (r_state == S_FILL) && !w_last;

  fb_addr_gen #(
    .FB_W (FB_W),
    .AW   (AW)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_step (w_step),
    .i_x    (w_cmd.x),
    .i_y    (w_cmd.y),
    .i_w    (w_w_eff),
    .i_h    (w_h_eff),
    .o_addr (fb_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_data  <= w_cmd.color;
            if (w_zero || w_reject) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_err   <= w_reject;
            end else begin
              r_state <= S_FILL;
              r_we    <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_last) begin
            r_state <= S_FIN;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign fb_we     = r_we;
  assign fb_data   = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
